// File: rtl/key_sched_ctrl.sv
// Round-key scheduler: starts the expander for the programmed key size, captures its
// streamed round keys into a 15-entry store and serves them by round index.
module key_sched_ctrl (
    input  logic         mclk,
    input  logic         arst_n,
    input  logic [1:0]   key_size,
    input  logic         key_load,
    output logic         start128,
    output logic         start192,
    output logic         start256,
    input  logic [0:127] rk128,
    input  logic [0:127] rk192,
    input  logic [0:127] rk256,
    input  logic         rk128_le,
    input  logic         rk192_le,
    input  logic         rk256_le,
    input  logic [3:0]   rk128_count,
    input  logic [3:0]   rk192_count,
    input  logic [3:0]   rk256_count,
    input  logic         busy128,
    input  logic         busy192,
    input  logic         busy256,
    output logic [3:0]   nr,
    output logic         key_ready,
    output logic         busy,
    output logic         size_err,
    input  logic         rd_en,
    input  logic [3:0]   rd_round,
    output logic [0:127] rk_out,
    output logic         rd_err
);
    localparam int unsigned RK_W  = 128;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned SLOTS = 15;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;
    localparam logic [1:0] S_READY  = 2'd3;

    localparam logic [1:0] KS_128  = 2'd0;
    localparam logic [1:0] KS_192  = 2'd1;
    localparam logic [1:0] KS_256  = 2'd2;
    localparam logic [1:0] KS_RSVD = 2'd3;

    logic [1:0]       state, state_d;
    logic [1:0]       sel, sel_d;
    logic [SLOTS-1:0] slot, slot_d;
    logic             done, done_d;
    logic [IDX_W-1:0] nr_d;
    logic             key_ready_d;
    logic             busy_d;
    logic             size_err_d;
    logic             start128_d, start192_d, start256_d;
    logic [0:RK_W-1]  rk_out_d;
    logic             rd_err_d;

    logic [0:RK_W-1]  store [SLOTS];

    logic             le_sel;
    logic [IDX_W-1:0] cnt_sel;
    logic [0:RK_W-1]  rk_sel;
    logic             wr_en;
    logic             final_wr;
    logic             load_ok;
    logic [SLOTS-1:0] low_mask;
    logic             unused_busy;

    // Expander busy lines are informational only; progress is tracked from the strobes.
    assign unused_busy = ^{busy128, busy192, busy256};

    // Only the latched expander's stream is observed.
    always_comb begin
        le_sel  = 1'b0;
        cnt_sel = '0;
        rk_sel  = '0;
        case (sel)
            KS_128: begin
                le_sel  = rk128_le;
                cnt_sel = rk128_count;
                rk_sel  = rk128;
            end
            KS_192: begin
                le_sel  = rk192_le;
                cnt_sel = rk192_count;
                rk_sel  = rk192;
            end
            KS_256: begin
                le_sel  = rk256_le;
                cnt_sel = rk256_count;
                rk_sel  = rk256;
            end
            default: begin
                le_sel  = 1'b0;
                cnt_sel = '0;
                rk_sel  = '0;
            end
        endcase
    end

    assign load_ok  = key_load && (key_size != KS_RSVD);
    assign wr_en    = (state == S_EXPAND) && le_sel && (cnt_sel <= nr);
    assign low_mask = (SLOTS'(1) << nr) - SLOTS'(1);
    // The schedule completes only when the last round lands on top of a full lower set.
    assign final_wr = wr_en && (cnt_sel == nr) && ((slot & low_mask) == low_mask);

    // Round-key store: data only, intentionally not reset.
    always_ff @(posedge mclk) begin
        if (wr_en) begin
            store[cnt_sel] <= rk_sel;
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d     = state;
        sel_d       = sel;
        slot_d      = slot;
        done_d      = 1'b0;
        nr_d        = nr;
        key_ready_d = key_ready;
        busy_d      = busy;
        size_err_d  = key_load && (key_size == KS_RSVD);
        start128_d  = 1'b0;
        start192_d  = 1'b0;
        start256_d  = 1'b0;
        rk_out_d    = rk_out;
        rd_err_d    = rd_err;

        case (state)
            S_IDLE, S_READY: begin
                if (load_ok) begin
                    sel_d       = key_size;
                    nr_d        = 4'd10 + {1'b0, key_size, 1'b0};
                    key_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    slot_d      = '0;
                    start128_d  = (key_size == KS_128);
                    start192_d  = (key_size == KS_192);
                    start256_d  = (key_size == KS_256);
                    state_d     = S_START;
                end
            end
            S_START: begin
                state_d = S_EXPAND;
            end
            S_EXPAND: begin
                if (wr_en) begin
                    slot_d = slot | (SLOTS'(1) << cnt_sel);
                end
                done_d = final_wr;
                if (done) begin
                    key_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_READY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reads are judged on the schedule state of the current cycle.
        if (rd_en) begin
            if (key_ready && (rd_round <= nr)) begin
                rk_out_d = store[rd_round];
                rd_err_d = 1'b0;
            end else begin
                rk_out_d = '0;
                rd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= S_IDLE;
            sel       <= KS_128;
            slot      <= '0;
            done      <= 1'b0;
            nr        <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b0;
            size_err  <= 1'b0;
            start128  <= 1'b0;
            start192  <= 1'b0;
            start256  <= 1'b0;
            rk_out    <= '0;
            rd_err    <= 1'b0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            slot      <= slot_d;
            done      <= done_d;
            nr        <= nr_d;
            key_ready <= key_ready_d;
            busy      <= busy_d;
            size_err  <= size_err_d;
            start128  <= start128_d;
            start192  <= start192_d;
            start256  <= start256_d;
            rk_out    <= rk_out_d;
            rd_err    <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Randomized bench for key_sched_ctrl: bench-driven expander streams checked against
// an array model of the round-key store and the schedule rules.
module tb_key_sched_ctrl;
    logic         mclk = 1'b0;
    logic         arst_n;
    logic [1:0]   key_size;
    logic         key_load;
    logic         start128, start192, start256;
    logic [0:127] rk128, rk192, rk256;
    logic         rk128_le, rk192_le, rk256_le;
    logic [3:0]   rk128_count, rk192_count, rk256_count;
    logic         busy128, busy192, busy256;
    logic [3:0]   nr;
    logic         key_ready, busy, size_err;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [0:127] rk_out;
    logic         rd_err;

    always #5 mclk = ~mclk;

    key_sched_ctrl dut (
        .mclk(mclk), .arst_n(arst_n), .key_size(key_size), .key_load(key_load),
        .start128(start128), .start192(start192), .start256(start256),
        .rk128(rk128), .rk192(rk192), .rk256(rk256),
        .rk128_le(rk128_le), .rk192_le(rk192_le), .rk256_le(rk256_le),
        .rk128_count(rk128_count), .rk192_count(rk192_count), .rk256_count(rk256_count),
        .busy128(busy128), .busy192(busy192), .busy256(busy256),
        .nr(nr), .key_ready(key_ready), .busy(busy), .size_err(size_err),
        .rd_en(rd_en), .rd_round(rd_round), .rk_out(rk_out), .rd_err(rd_err)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_s128 = 0, n_s192 = 0, n_s256 = 0;
    int e128 = 0, e192 = 0, e256 = 0;

    // Reference model of the schedule.
    logic [127:0] m_store [15];
    bit           m_ready = 1'b0;
    int           m_nr    = 0;

    always @(negedge mclk) begin
        if (start128) n_s128++;
        if (start192) n_s192++;
        if (start256) n_s256++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge mclk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Known FIPS-197 round keys; bit 128 flags a known value.
    function automatic logic [128:0] fips_rk(input int s, input int r);
        if (r == 0)             return {1'b1, 128'h000102030405060708090a0b0c0d0e0f};
        if (s == 1 && r == 1)   return {1'b1, 128'h10111213141516175846f2f95c43f4fe};
        if (s == 1 && r == 12)  return {1'b1, 128'ha4970a331a78dc09c418c271e3a41d5d};
        if (s == 0 && r == 10)  return {1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        if (s == 2 && r == 1)   return {1'b1, 128'h101112131415161718191a1b1c1d1e1f};
        if (s == 2 && r == 14)  return {1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        return '0;
    endfunction

    task automatic set_ch(input int ch, input logic le, input int cnt, input logic [127:0] v);
        case (ch)
            0: begin rk128_le = le; rk128_count = 4'(cnt); rk128 = v; end
            1: begin rk192_le = le; rk192_count = 4'(cnt); rk192 = v; end
            default: begin rk256_le = le; rk256_count = 4'(cnt); rk256 = v; end
        endcase
    endtask

    task automatic check_reset(input string t);
        check({t, "_nr"},       128'(nr),        128'(0));
        check({t, "_ready"},    128'(key_ready), 128'(0));
        check({t, "_busy"},     128'(busy),      128'(0));
        check({t, "_size_err"}, 128'(size_err),  128'(0));
        check({t, "_starts"},   128'({start128, start192, start256}), 128'(0));
        check({t, "_rk_out"},   rk_out,          128'(0));
        check({t, "_rd_err"},   128'(rd_err),    128'(0));
    endtask

    // Load request; rd_r >= 0 issues a read in the same cycle.
    task automatic do_load(input int ks, input int rd_r);
        logic [127:0] er;
        logic         ee;
        er = '0;
        ee = 1'b1;
        if (m_ready && rd_r <= m_nr) begin
            er = m_store[rd_r];
            ee = 1'b0;
        end
        key_size = 2'(ks);
        key_load = 1'b1;
        if (rd_r >= 0) begin
            rd_en    = 1'b1;
            rd_round = 4'(rd_r);
        end
        tick();
        key_load = 1'b0;
        rd_en    = 1'b0;
        m_ready  = 1'b0;
        m_nr     = 10 + 2 * ks;
        if (ks == 0) e128++;
        if (ks == 1) e192++;
        if (ks == 2) e256++;
        if (rd_r >= 0) begin
            check("restart_rd_rk",  rk_out,          er);
            check("restart_rd_err", 128'(rd_err),    128'(ee));
        end
        check("ld_start128", 128'(start128),  128'(ks == 0));
        check("ld_start192", 128'(start192),  128'(ks == 1));
        check("ld_start256", 128'(start256),  128'(ks == 2));
        check("ld_busy",     128'(busy),      128'(1));
        check("ld_ready",    128'(key_ready), 128'(0));
        check("ld_nr",       128'(nr),        128'(m_nr));
        tick();
        check("ld_starts_off", 128'({start128, start192, start256}), 128'(0));
    endtask

    // Stream round keys on channel s in random order, with rewrites, out-of-range
    // strobes, foreign-channel noise, an optional ignored load and optional reset.
    task automatic run_stream(input int s, input bit inject, input bit midload, input int rst_at);
        int           n;
        int           nj;
        int           cq[$];
        logic [127:0] kq[$];
        logic [127:0] real_k [15];
        int           ord [15];
        bit           marked [15];
        bit           live;
        bit           fin;
        logic [128:0] f;
        n = m_nr;
        for (int r = 0; r <= n; r++) begin
            f = fips_rk(s, r);
            real_k[r] = f[128] ? f[127:0] : rnd128();
        end
        for (int r = 0; r < 15; r++) marked[r] = 1'b0;
        nj = int'($urandom_range(3, 1));
        for (int j = 0; j < nj; j++) begin
            cq.push_back(int'($urandom_range(n - 1)));
            kq.push_back(rnd128());
        end
        cq.push_back(n);
        kq.push_back(rnd128());
        for (int i = 0; i < n; i++) ord[i] = i;
        for (int i = n - 1; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i));
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < n; i++) begin
            cq.push_back(ord[i]);
            kq.push_back(real_k[ord[i]]);
            if ($urandom_range(3) == 0) begin
                cq.push_back(int'($urandom_range(15, n + 1)));
                kq.push_back(rnd128());
            end
        end
        cq.push_back(n);
        kq.push_back(real_k[n]);

        live = 1'b1;
        fin  = 1'b0;
        for (int i = 0; i < cq.size() && !fin; i++) begin
            bit do_rd;
            do_rd = (rst_at != i) && ($urandom_range(1) == 1);
            set_ch(s, 1'b1, cq[i], kq[i]);
            for (int ch = 0; ch < 3; ch++) begin
                if (ch != s) begin
                    if (inject && i == 1) set_ch(ch, 1'b1, 3, '1);
                    else if ($urandom_range(3) == 0) set_ch(ch, 1'b1, int'($urandom_range(n)), '1);
                end
            end
            if (midload && i == 2) begin
                key_load = 1'b1;
                key_size = 2'd0;
            end
            if (do_rd) begin
                rd_en    = 1'b1;
                rd_round = 4'($urandom_range(15));
            end
            if (rst_at == i) begin
                arst_n = 1'b0;
                #1;
                check_reset("mid_rst");
                live    = 1'b0;
                m_ready = 1'b0;
                m_nr    = 0;
            end
            tick();
            if (rst_at == i) arst_n = 1'b1;
            key_load = 1'b0;
            rd_en    = 1'b0;
            for (int ch = 0; ch < 3; ch++) set_ch(ch, 1'b0, 0, '0);
            if (live && cq[i] <= n) begin
                m_store[cq[i]] = kq[i];
                if (cq[i] == n) begin
                    fin = 1'b1;
                    for (int r = 0; r < n; r++) if (!marked[r]) fin = 1'b0;
                end
                marked[cq[i]] = 1'b1;
            end
            if (do_rd) begin
                check("strm_rd_err", 128'(rd_err), 128'(1));
                check("strm_rd_rk",  rk_out,       128'(0));
            end
            check("strm_ready_lo", 128'(key_ready), 128'(0));
            check("strm_busy",     128'(busy),      128'(live));
        end
        if (live) begin
            tick();
            check("fin_ready", 128'(key_ready), 128'(1));
            check("fin_busy",  128'(busy),      128'(0));
            check("fin_nr",    128'(nr),        128'(n));
            m_ready = 1'b1;
        end else begin
            check("rst_ready", 128'(key_ready), 128'(0));
            check("rst_busy",  128'(busy),      128'(0));
            check("rst_nr",    128'(nr),        128'(0));
        end
    endtask

    // Model-checked read; with hold, a following idle cycle must keep the result.
    task automatic rd_model(input int r, input string t, input bit hold);
        logic [127:0] er;
        logic         ee;
        if (m_ready && r <= m_nr) begin
            er = m_store[r];
            ee = 1'b0;
        end else begin
            er = '0;
            ee = 1'b1;
        end
        rd_en    = 1'b1;
        rd_round = 4'(r);
        tick();
        rd_en = 1'b0;
        check({t, "_rk"},  rk_out,       er);
        check({t, "_err"}, 128'(rd_err), 128'(ee));
        if (hold) begin
            rd_round = 4'($urandom_range(15));
            tick();
            check({t, "_hold_rk"},  rk_out,       er);
            check({t, "_hold_err"}, 128'(rd_err), 128'(ee));
        end
    endtask

    task automatic rd_const(input int r, input logic [127:0] v, input string t);
        rd_en    = 1'b1;
        rd_round = 4'(r);
        tick();
        rd_en = 1'b0;
        check(t,           rk_out,       v);
        check({t, "_err"}, 128'(rd_err), 128'(0));
    endtask

    task automatic sweep(input int k);
        for (int i = 0; i < k; i++) rd_model(int'($urandom_range(15)), "sweep", ($urandom_range(3) == 0));
    endtask

    initial begin
        arst_n   = 1'b0;
        key_size = 2'd0;
        key_load = 1'b0;
        rd_en    = 1'b0;
        rd_round = 4'd0;
        busy128  = 1'b0;
        busy192  = 1'b0;
        busy256  = 1'b0;
        for (int ch = 0; ch < 3; ch++) set_ch(ch, 1'b0, 0, '0);
        tick();
        tick();
        check_reset("por");
        arst_n = 1'b1;
        tick();

        // AES-192 with foreign-channel noise and an ignored mid-expansion load.
        do_load(1, -1);
        run_stream(1, 1'b1, 1'b1, -1);
        rd_const(0,  128'h000102030405060708090a0b0c0d0e0f, "a192_r0");
        rd_const(1,  128'h10111213141516175846f2f95c43f4fe, "a192_r1");
        rd_const(12, 128'ha4970a331a78dc09c418c271e3a41d5d, "a192_r12");
        rd_model(3, "a192_r3", 1'b1);
        sweep(6);

        // AES-128 from READY.
        do_load(0, -1);
        run_stream(0, 1'b0, 1'b0, -1);
        rd_const(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "a128_r10");
        rd_model(11, "a128_r11", 1'b1);
        sweep(4);

        // Reserved key size.
        key_size = 2'd3;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("rsvd_size_err", 128'(size_err),  128'(1));
        check("rsvd_ready",    128'(key_ready), 128'(1));
        check("rsvd_nr",       128'(nr),        128'(10));
        check("rsvd_busy",     128'(busy),      128'(0));
        check("rsvd_starts",   128'({start128, start192, start256}), 128'(0));
        tick();
        check("rsvd_size_err_off", 128'(size_err), 128'(0));
        rd_const(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "rsvd_r10");

        // Restart to AES-256 with a same-cycle read served from the old schedule.
        do_load(2, 5);
        run_stream(2, 1'b1, 1'b0, -1);
        rd_const(14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "a256_r14");
        rd_model(15, "a256_r15", 1'b0);
        sweep(4);

        // Reset at the 5th strobe, trailing strobes ignored, then a fresh schedule.
        do_load(1, -1);
        run_stream(1, 1'b0, 1'b0, 4);
        rd_model(0, "post_rst_rd", 1'b0);
        do_load(1, -1);
        run_stream(1, 1'b0, 1'b0, -1);
        rd_const(12, 128'ha4970a331a78dc09c418c271e3a41d5d, "fresh_r12");
        sweep(4);

        for (int k = 0; k < 4; k++) begin
            int ks;
            ks = int'($urandom_range(2));
            do_load(ks, ($urandom_range(1) == 1) ? int'($urandom_range(15)) : -1);
            run_stream(ks, ($urandom_range(1) == 1), ($urandom_range(1) == 1), -1);
            sweep(5);
        end

        check("start128_count", 128'(n_s128), 128'(e128));
        check("start192_count", 128'(n_s192), 128'(e192));
        check("start256_count", 128'(n_s256), 128'(e256));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Round-key scheduler between the three key expanders (key128_exp, key192_exp, key256_exp) and the cipher round datapath. On a load request it selects the expander for the programmed key size, pulses that expander's start, and captures every streamed round key into a 15-entry × 128-bit round-key store. It then flags the schedule ready and serves round keys by index to the round engine through a registered read port.

## Interface
- No parameters.
- mclk  in  1  master clock, all state on rising edge
- arst_n  in  1  asynchronous reset, active-low
- key_size  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved; sampled on key_load
- key_load  in  1  one-cycle request to expand a new key
- start128 / start192 / start256  out  1 each  one-cycle start pulse to the selected expander
- rk128 / rk192 / rk256  in  [0:127] each  round key from the expander
- rk128_le / rk192_le / rk256_le  in  1 each  round key valid strobe
- rk128_count / rk192_count / rk256_count  in  4 each  round index of the presented key
- busy128 / busy192 / busy256  in  1 each  expander busy
- nr  out  4  round count of the latched size: 10, 12 or 14; 0 after reset
- key_ready  out  1  round-key store holds a complete schedule
- busy  out  1  expansion in progress
- size_err  out  1  one-cycle pulse when key_load is seen with key_size=11
- rd_en  in  1  read request
- rd_round  in  4  round index to read
- rk_out  out  [0:127]  registered round key
- rd_err  out  1  registered; rd_round > nr, or store not ready

## Operation
- States: IDLE, START, EXPAND, READY.
- IDLE or READY, key_load=1, key_size valid:
  - latch the size into sel and set nr.
  - clear key_ready, clear the written-slot vector.
  - go to START.
- START:
  - assert only start<sel> for exactly one cycle.
  - set busy=1.
  - go to EXPAND.
- EXPAND:
  - Only the selected expander's le/count/rk are observed. Strobes from the other expanders are ignored.
  - On rk<sel>_le=1 with count ≤ nr: store[count] <= rk<sel> and mark slot[count] written.
  - Strobes with count > nr are dropped.
  - Rewriting a slot overwrites it.
  - Completion is a write whose count equals nr while every slot 0..nr-1 is already marked. Next cycle: state=READY, key_ready=1, busy=0.
  - A write with count = nr while any lower slot is unmarked does not complete. The block stays in EXPAND.
- key_load in START or EXPAND is ignored; no restart.
- key_load with key_size=11 in any state:
  - size_err pulses for one cycle.
  - No state, nr or store change.
- key_load in READY with a valid size:
  - restarts the sequence.
  - key_ready drops the next cycle.
  - Old store contents remain readable only via rd_err=1 (rk_out=0) until the new schedule completes.
- Read port, every cycle with rd_en=1:
  - if key_ready=1 and rd_round ≤ nr: rk_out <= store[rd_round], rd_err <= 0.
  - otherwise: rk_out <= 0, rd_err <= 1.
  - rd_en=0: rk_out and rd_err hold.
- Reads are allowed in the same cycle as a restart key_load. That read is still served from the old schedule because key_ready is still 1 in that cycle.

## Timing
- Reset values: start128/192/256=0, nr=0, key_ready=0, busy=0, size_err=0, rk_out=0, rd_err=0, state=IDLE, slot vector cleared.
- Store contents are not reset.
- key_load at cycle T → start<sel> high in T+1 → busy high from T+1.
- Round-key capture: le sampled at edge E → store updated at edge E.
- Final-key capture at edge E → key_ready=1 and busy=0 visible after edge E+1.
- Read latency is one cycle: rd_en at T → rk_out valid after edge T+1.
- Reset mid-operation forces IDLE at once. A running expander is left alone; its later strobes are ignored because the state is IDLE.

## Test plan
- AES-192, FIPS-197 key 000102…1617, key_load with key_size=01:
  - start192 pulses once; start128 and start256 stay 0.
  - key_ready=1 after rk192_count=12 is captured; nr=12.
  - read 0 → 000102030405060708090a0b0c0d0e0f.
  - read 1 → 1011121314151617 5846f2f9 5c43f4fe.
  - read 12 → a4970a331a78dc09c418c271e3a41d5d.
- AES-128 key 000102…0f:
  - nr=10.
  - read 10 → 13111d7fe3944a17f307a78b4d2b30c5.
  - read 11 → rd_err=1, rk_out=0.
- key_size=11:
  - size_err pulses once.
  - state, nr and key_ready unchanged from the previous AES-128 schedule.
- During AES-192 expansion, inject rk128_le=1, rk128_count=3, rk128=all-ones:
  - store[3] is unaffected.
  - key_load pulsed mid-EXPAND gives no new start pulse.
- From READY, key_load with key_size=10:
  - key_ready drops next cycle; reads return rd_err=1 until round 14 is captured.
  - rk_out for round 14 matches the FIPS-197 AES-256 value 24fc79ccbf0979e9371ac23c6d68de36.
- Assert arst_n=0 at the 5th round-key strobe:
  - all outputs return to reset values.
  - the remaining expander strobes are ignored.
  - a fresh key_load completes normally.
